div_sched: RTL and testbench

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched.sv | 130 +++++++++++++
 tb/tb_div_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Two-requester scheduler around one restoring shift-subtract divider.
// Define DIV_SCHED_RR_EN for round-robin arbitration; the default is fixed priority with requester 0 first.
module div_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_div_by_zero,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [CW-1:0]    iter;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;

`ifdef DIV_SCHED_RR_EN
  logic last;

  // On contention the requester that was not served last wins.
  always_comb grant1 = req1_valid && (!req0_valid || !last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant1;
    end
  end
`else
  always_comb grant1 = req1_valid && !req0_valid;
`endif

  assign accept       = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready   = (state == IDLE) && req0_valid && !grant1;
  assign req1_ready   = (state == IDLE) && grant1;
  assign sel_dividend = grant1 ? req1_dividend : req0_dividend;
  assign sel_divisor  = grant1 ? req1_divisor  : req0_divisor;

  // The dividend shifts out of quo MSB first while quotient bits shift in.
  // Because rem < dsr always holds, the top bit of diff is exactly the borrow.
  assign trial    = {rem, quo[WIDTH-1]};
  assign diff     = trial - {1'b0, dsr};
  assign fits     = !diff[WIDTH];
  assign rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      iter            <= '0;
      quo             <= '0;
      dsr             <= '0;
      rem             <= '0;
      rsp_id          <= 1'b0;
      rsp_quotient    <= '0;
      rsp_remainder   <= '0;
      rsp_div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            quo    <= sel_dividend;
            dsr    <= sel_divisor;
            rem    <= '0;
            iter   <= '0;
            rsp_id <= grant1;
            if (sel_divisor == '0) begin
              state           <= DONE;
              rsp_quotient    <= '0;
              rsp_remainder   <= '0;
              rsp_div_by_zero <= 1'b1;
            end else begin
              state           <= CALC;
              rsp_div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          quo  <= quo_next;
          rem  <= rem_next;
          iter <= iter + 1'b1;
          if (iter == CW'(WIDTH - 1)) begin
            state         <= DONE;
            rsp_quotient  <= quo_next;
            rsp_remainder <= rem_next;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed vector table, contention, hold,
// mid-operation reset and randomized operations against an arithmetic model.
module tb_div_sched;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_div_by_zero, busy;
  logic [WIDTH-1:0] rsp_quotient, rsp_remainder;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  div_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_div_by_zero(rsp_div_by_zero), .busy(busy)
  );

  typedef struct {
    bit          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    bit          dbz;
    int          lat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic waitValid(output bit ok);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ok = rsp_valid;
  endtask

  task automatic takeResponse();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Issues one operation, scrambles the operands after acceptance, measures
  // edges from the acceptance edge to rsp_valid, then stalls and handshakes.
  // Zero-divisor results are visible right after the acceptance edge (lat 0).
  task automatic applyStimulus(input bit id, input logic [15:0] a, input logic [15:0] b,
                               input int stall, output bit got_id, output logic [15:0] q,
                               output logic [15:0] r, output bit dbz, output int lat,
                               output bit ok);
    int n = 0;
    ok = 1'b1; lat = -1; got_id = 1'b0; q = '0; r = '0; dbz = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_dividend = a; req1_divisor = b; end
    else    begin req0_valid = 1'b1; req0_dividend = a; req0_divisor = b; end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      ok = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_dividend = 16'($urandom); req0_divisor = 16'($urandom);
    req1_dividend = 16'($urandom); req1_divisor = 16'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      ok = 1'b0;
      return;
    end
    repeat (stall) begin @(posedge clk); #1; end
    got_id = rsp_id; q = rsp_quotient; r = rsp_remainder; dbz = rsp_div_by_zero;
    takeResponse();
  endtask

  task automatic runVec(input vec_t v, input string tag, input int stall);
    bit gid, dbz, ok;
    logic [15:0] q, r;
    int lat;
    applyStimulus(v.id, v.a, v.b, stall, gid, q, r, dbz, lat, ok);
    checkOutput({tag, " completed"}, 32'(ok), 32'd1);
    checkOutput({tag, " latency"}, lat, v.lat);
    checkOutput({tag, " rsp_id"}, 32'(gid), 32'(v.id));
    checkOutput({tag, " quotient"}, 32'(q), 32'(v.q));
    checkOutput({tag, " remainder"}, 32'(r), 32'(v.r));
    checkOutput({tag, " div_by_zero"}, 32'(dbz), 32'(v.dbz));
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[10];
    vec_t v;
    bit ok, gid, dbz;
    logic [15:0] q, r, a, b;
    int lat, seen, expId;

    vecs[0] = '{1'b0, 16'd798,   16'd11,    16'd72,    16'd6,     1'b0, WIDTH};
    vecs[1] = '{1'b1, 16'd255,   16'd5,     16'd51,    16'd0,     1'b0, WIDTH};
    vecs[2] = '{1'b1, 16'd3,     16'd7,     16'd0,     16'd3,     1'b0, WIDTH};
    vecs[3] = '{1'b0, 16'd70,    16'd0,     16'd0,     16'd0,     1'b1, 0};
    vecs[4] = '{1'b0, 16'd0,     16'd5,     16'd0,     16'd0,     1'b0, WIDTH};
    vecs[5] = '{1'b1, 16'd65535, 16'd1,     16'd65535, 16'd0,     1'b0, WIDTH};
    vecs[6] = '{1'b0, 16'd65535, 16'd65535, 16'd1,     16'd0,     1'b0, WIDTH};
    vecs[7] = '{1'b1, 16'd1,     16'd65535, 16'd0,     16'd1,     1'b0, WIDTH};
    vecs[8] = '{1'b1, 16'd65535, 16'd0,     16'd0,     16'd0,     1'b1, 0};
    vecs[9] = '{1'b0, 16'd40000, 16'd300,   16'd133,   16'd100,   1'b0, WIDTH};

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_dividend = '0; req0_divisor = '0; req1_dividend = '0; req1_divisor = '0;
    #3;
    checkOutput("reset rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset rsp_id", 32'(rsp_id), 0);
    checkOutput("reset quotient", 32'(rsp_quotient), 0);
    checkOutput("reset remainder", 32'(rsp_remainder), 0);
    checkOutput("reset div_by_zero", 32'(rsp_div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i), i % 3);
    end

    // Contention from reset: req0 first, then req1 once req0 drops.
    doReset();
    req0_valid = 1'b1; req0_dividend = 16'd200; req0_divisor = 16'd40;
    req1_valid = 1'b1; req1_dividend = 16'd90;  req1_divisor = 16'd9;
    #1;
    checkOutput("contend req0_ready", 32'(req0_ready), 1);
    checkOutput("contend req1_ready", 32'(req1_ready), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    waitValid(ok);
    checkOutput("contend first done", 32'(ok), 1);
    checkOutput("contend first id", 32'(rsp_id), 0);
    checkOutput("contend first quotient", 32'(rsp_quotient), 5);
    checkOutput("contend first remainder", 32'(rsp_remainder), 0);
    rsp_ready = 1'b1; #1;
    checkOutput("handshake cycle req1_ready", 32'(req1_ready), 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("after handshake req1_ready", 32'(req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    waitValid(ok);
    checkOutput("contend second done", 32'(ok), 1);
    checkOutput("contend second id", 32'(rsp_id), 1);
    checkOutput("contend second quotient", 32'(rsp_quotient), 10);
    checkOutput("contend second remainder", 32'(rsp_remainder), 0);
    takeResponse();

    // Both held valid: grant sequence depends on the arbitration build.
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef DIV_SCHED_RR_EN
      expId = g % 2;
`else
      expId = 0;
`endif
      #1;
      checkOutput($sformatf("grant%0d req0_ready", g), 32'(req0_ready), 32'(expId == 0));
      checkOutput($sformatf("grant%0d req1_ready", g), 32'(req1_ready), 32'(expId == 1));
      @(posedge clk); #1;
      waitValid(ok);
      checkOutput($sformatf("grant%0d done", g), 32'(ok), 1);
      checkOutput($sformatf("grant%0d id", g), 32'(rsp_id), 32'(expId));
      checkOutput($sformatf("grant%0d quotient", g), 32'(rsp_quotient), expId == 0 ? 5 : 10);
      takeResponse();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Hold: consumer stalls for 10 cycles while new requests wait.
    req0_valid = 1'b1; req0_dividend = 16'd16; req0_divisor = 16'd3;
    #1;
    @(posedge clk); #1;
    req0_dividend = 16'd999; req0_divisor = 16'd2;
    req1_valid = 1'b1; req1_dividend = 16'd7; req1_divisor = 16'd1;
    waitValid(ok);
    checkOutput("hold done", 32'(ok), 1);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("hold%0d rsp_valid", i), 32'(rsp_valid), 1);
      checkOutput($sformatf("hold%0d quotient", i), 32'(rsp_quotient), 5);
      checkOutput($sformatf("hold%0d remainder", i), 32'(rsp_remainder), 1);
      checkOutput($sformatf("hold%0d busy", i), 32'(busy), 1);
      checkOutput($sformatf("hold%0d readies", i), {30'd0, req1_ready, req0_ready}, 0);
      @(posedge clk); #1;
    end
    takeResponse();
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset pulsed at CALC iteration 8 of a req1 operation.
    req1_valid = 1'b1; req1_dividend = 16'd1000; req1_divisor = 16'd7;
    #1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset rsp_valid", 32'(rsp_valid), 0);
    checkOutput("midreset busy", 32'(busy), 0);
    checkOutput("midreset rsp_id", 32'(rsp_id), 0);
    checkOutput("midreset quotient", 32'(rsp_quotient), 0);
    checkOutput("midreset remainder", 32'(rsp_remainder), 0);
    checkOutput("midreset div_by_zero", 32'(rsp_div_by_zero), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    checkOutput("midreset no response", seen, 0);
    v = '{1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, WIDTH};
    runVec(v, "after reset", 0);

    // Randomized operations against plain integer division.
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = 16'($urandom);
      if (sel == 0)      b = 16'd0;
      else if (sel < 4)  b = 16'($urandom_range(1, 20));
      else               b = 16'($urandom);
      v.id  = 1'($urandom_range(0, 1));
      v.a   = a;
      v.b   = b;
      v.q   = (b == 0) ? 16'd0 : a / b;
      v.r   = (b == 0) ? 16'd0 : a % b;
      v.dbz = (b == 0);
      v.lat = (b == 0) ? 0 : WIDTH;
      runVec(v, $sformatf("rand%0d", i), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
